// File: rtl/spec_acc_rmw.sv
// spec_acc_rmw: sums N pulses of per-bin spectra into signal/BG DPRAMs by read-modify-write,
// with a pulse-count FSM and a saturating accumulate.
module spec_acc_rmw #(
    parameter int IDX_W   = 10,
    parameter int BIN_W   = 5,
    parameter int BG_BINS = 2,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 40,
    parameter int RD_LAT  = 2,
    localparam int ADDR_W = BIN_W + IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       pulse_num,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  data_index,
    input  logic [BIN_W-1:0]  RangeBin_Counter,
    input  logic              BG_Deduction_En,
    input  logic              Peak_Detection_En,
    input  logic [ACC_W-1:0]  rd_data_in,
    output logic [ADDR_W-1:0] rdaddr_out,
    output logic              rd_bg_sel,
    output logic [ADDR_W-1:0] wraddr_out,
    output logic [ACC_W-1:0]  wr_data_out,
    output logic              DPRAM_wea,
    output logic              DPRAM_BG_wea,
    output logic              acc_busy,
    output logic [15:0]       pulse_cnt,
    output logic              sat_flag,
    output logic              SPEC_Acc_Done
);
    localparam int L = RD_LAT + 2;
    typedef enum logic [2:0] {IDLE, ARM, ACC, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] drain_cnt;
    logic [15:0] pulse_tgt;
    logic run_start, drain_end, last_pulse, accept, in_bg, sat;
    logic [ADDR_W-1:0] in_addr;
    logic [RD_LAT:0] p_v, p_bg, p_first;
    logic [DATA_W-1:0] p_data [RD_LAT+1];
    logic [ADDR_W-1:0] p_addr [RD_LAT+1];
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] wr_nx;

    assign run_start  = state == IDLE && start;
    assign drain_end  = state == DRAIN && drain_cnt == 8'(L - 1);
    assign last_pulse = 16'(pulse_cnt + 16'd1) == pulse_tgt;
    assign accept     = data_valid_in && (state == ARM || state == ACC) && RangeBin_Counter != '0;
    assign in_bg      = RangeBin_Counter <= BIN_W'(BG_BINS);
    assign in_addr    = in_bg ? {RangeBin_Counter - BIN_W'(1), data_index}
                              : {RangeBin_Counter - BIN_W'(BG_BINS + 1), data_index};

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ARM : IDLE;
            ARM:     state_nx = data_valid_in ? ACC : ARM;
            ACC:     state_nx = data_valid_in ? ACC : DRAIN;
            DRAIN:   state_nx = drain_end ? (last_pulse ? DONE : ARM) : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        acc_busy      = state == ARM || state == ACC || state == DRAIN;
        SPEC_Acc_Done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            drain_cnt <= '0;
            pulse_cnt <= '0;
            pulse_tgt <= '0;
        end else begin
            drain_cnt <= state == DRAIN ? drain_cnt + 8'd1 : 8'd0;
            if (run_start) begin
                pulse_cnt <= '0;
                pulse_tgt <= pulse_num == 16'd0 ? 16'd1 : pulse_num;
            end else if (drain_end) pulse_cnt <= pulse_cnt + 16'd1;
        end

    // Each sample carries its own first-pulse flag so pulse_cnt may advance while it is in flight.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            p_v     <= '0;
            p_bg    <= '0;
            p_first <= '0;
            p_data  <= '{default: '0};
            p_addr  <= '{default: '0};
        end else begin
            p_v       <= {p_v[RD_LAT-1:0], accept};
            p_bg      <= {p_bg[RD_LAT-1:0], in_bg};
            p_first   <= {p_first[RD_LAT-1:0], pulse_cnt == 16'd0};
            p_data[0] <= data_in;
            p_addr[0] <= in_addr;
            for (int i = 1; i <= RD_LAT; i++) begin
                p_data[i] <= p_data[i-1];
                p_addr[i] <= p_addr[i-1];
            end
        end

    assign rdaddr_out = p_addr[0];
    assign rd_bg_sel  = p_bg[0];
    assign sum   = {1'b0, rd_data_in} + (ACC_W + 1)'(p_data[RD_LAT]);
    assign sat   = !p_first[RD_LAT] && sum[ACC_W];
    assign wr_nx = p_first[RD_LAT] ? ACC_W'(p_data[RD_LAT]) : (sat ? '1 : sum[ACC_W-1:0]);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wraddr_out   <= '0;
            wr_data_out  <= '0;
            DPRAM_wea    <= 1'b0;
            DPRAM_BG_wea <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            wraddr_out   <= p_addr[RD_LAT];
            wr_data_out  <= wr_nx;
            DPRAM_wea    <= p_v[RD_LAT] && !p_bg[RD_LAT] && !Peak_Detection_En;
            DPRAM_BG_wea <= p_v[RD_LAT] && p_bg[RD_LAT] && !BG_Deduction_En && !Peak_Detection_En;
            if (run_start) sat_flag <= 1'b0;
            else if (p_v[RD_LAT] && sat) sat_flag <= 1'b1;
        end
endmodule

// File: tb/tb_spec_acc_rmw.sv
// tb_spec_acc_rmw: scoreboard bench with DPRAM model and arithmetic reference for spec_acc_rmw.
module tb_spec_acc_rmw;
    localparam int IDX_W = 10, BIN_W = 5, BG_BINS = 2, DATA_W = 32, ACC_W = 40, RD_LAT = 2;
    localparam int ADDR_W = BIN_W + IDX_W, L = RD_LAT + 2, DEPTH = 1 << ADDR_W, GAP = 10;
    localparam logic [ACC_W:0] MAX = {1'b0, {ACC_W{1'b1}}};

    typedef struct {
        bit bg;
        int addr;
        logic [ACC_W-1:0] data;
        longint cyc;
    } exp_t;

    logic clk = 0, rst = 1, start = 0, data_valid_in = 0;
    logic BG_Deduction_En = 0, Peak_Detection_En = 0;
    logic [15:0] pulse_num = 0;
    logic [DATA_W-1:0] data_in = 0;
    logic [IDX_W-1:0] data_index = 0;
    logic [BIN_W-1:0] RangeBin_Counter = 0;
    logic [ACC_W-1:0] rd_data_in;
    logic [ADDR_W-1:0] rdaddr_out, wraddr_out;
    logic rd_bg_sel, DPRAM_wea, DPRAM_BG_wea, acc_busy, sat_flag, SPEC_Acc_Done;
    logic [ACC_W-1:0] wr_data_out;
    logic [15:0] pulse_cnt;

    logic [ACC_W-1:0] sig_mem [DEPTH] = '{default: '0};
    logic [ACC_W-1:0] bg_mem  [DEPTH] = '{default: '0};
    logic [ACC_W-1:0] ref_sig [DEPTH] = '{default: '0};
    logic [ACC_W-1:0] ref_bg  [DEPTH] = '{default: '0};
    logic [ACC_W-1:0] rd_q [RD_LAT] = '{default: '0};
    logic pre_en = 0;
    logic [ADDR_W-1:0] pre_addr = 0;
    logic [ACC_W-1:0] pre_val = 0;
    longint cyc = 0;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0, wr_cnt = 0, done_cnt = 0, n_exp = 0;
    logic [15:0] exp_tgt = 0;
    bit exp_sat = 0;

    spec_acc_rmw #(.IDX_W(IDX_W), .BIN_W(BIN_W), .BG_BINS(BG_BINS), .DATA_W(DATA_W),
                   .ACC_W(ACC_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .pulse_num(pulse_num),
        .data_valid_in(data_valid_in), .data_in(data_in), .data_index(data_index),
        .RangeBin_Counter(RangeBin_Counter), .BG_Deduction_En(BG_Deduction_En),
        .Peak_Detection_En(Peak_Detection_En), .rd_data_in(rd_data_in),
        .rdaddr_out(rdaddr_out), .rd_bg_sel(rd_bg_sel), .wraddr_out(wraddr_out),
        .wr_data_out(wr_data_out), .DPRAM_wea(DPRAM_wea), .DPRAM_BG_wea(DPRAM_BG_wea),
        .acc_busy(acc_busy), .pulse_cnt(pulse_cnt), .sat_flag(sat_flag),
        .SPEC_Acc_Done(SPEC_Acc_Done));

    always #5 clk = ~clk;

    // Dual DPRAM model with RD_LAT read latency; writes land on the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_q[0] <= rd_bg_sel ? bg_mem[rdaddr_out] : sig_mem[rdaddr_out];
        for (int k = 1; k < RD_LAT; k++) rd_q[k] <= rd_q[k-1];
        if (DPRAM_wea) sig_mem[wraddr_out] <= wr_data_out;
        if (DPRAM_BG_wea) bg_mem[wraddr_out] <= wr_data_out;
        if (pre_en) sig_mem[pre_addr] <= pre_val;
    end
    assign rd_data_in = rd_q[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (DPRAM_wea || DPRAM_BG_wea) begin
                    wr_cnt++;
                    chk("wr_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_data", {DPRAM_BG_wea, DPRAM_wea, wraddr_out, wr_data_out},
                            {e.bg, !e.bg, ADDR_W'(e.addr), e.data});
                        chk("wr_cycle", cyc, e.cyc);
                    end
                end
                if (SPEC_Acc_Done) begin
                    done_cnt++;
                    chk("done_pulse_cnt", pulse_cnt, exp_tgt);
                end
            end
        end
    endtask

    task automatic model(input int b, input int i, input logic [DATA_W-1:0] d, input bit first);
        bit bg;
        int a;
        logic [ACC_W:0] s;
        if (b == 0) return;
        bg = b <= BG_BINS;
        a = ((bg ? b - 1 : b - 1 - BG_BINS) << IDX_W) + i;
        s = first ? (ACC_W + 1)'(d)
                  : (ACC_W + 1)'(bg ? ref_bg[a] : ref_sig[a]) + (ACC_W + 1)'(d);
        if (s > MAX) begin
            s = MAX;
            exp_sat = 1;
        end
        if (Peak_Detection_En || (bg && BG_Deduction_En)) return;
        if (bg) ref_bg[a] = s[ACC_W-1:0];
        else ref_sig[a] = s[ACC_W-1:0];
        exp_q.push_back('{bg, a, s[ACC_W-1:0], cyc + L});
        n_exp++;
    endtask

    task automatic send_pulse(input int b0, nb, i0, ni, mode, cval, input bit first, input bit inj);
        int n = 0;
        logic [DATA_W-1:0] d;
        for (int b = b0; b < b0 + nb; b++)
            for (int i = i0; i < i0 + ni; i++) begin
                d = mode == 0 ? DATA_W'(cval) : mode == 1 ? DATA_W'($urandom) : DATA_W'(b * 16 + i);
                data_valid_in = 1;
                RangeBin_Counter = BIN_W'(b);
                data_index = IDX_W'(i);
                data_in = d;
                if (inj && n == 3) begin
                    start = 1;
                    pulse_num = 16'd9;
                end else start = 0;
                model(b, i, d, first);
                n++;
                tick();
            end
        data_valid_in = 0;
        start = 0;
        repeat (GAP) tick();
    endtask

    task automatic run(input int pn, b0, nb, i0, ni, mode, cval, input bit bgd, pk, sat_t, inj);
        int tgt, d0, w0, e0;
        tgt = pn == 0 ? 1 : pn;
        d0 = done_cnt;
        w0 = wr_cnt;
        e0 = n_exp;
        BG_Deduction_En = bgd;
        Peak_Detection_En = pk;
        exp_tgt = 16'(tgt);
        exp_sat = 0;
        start = 1;
        pulse_num = 16'(pn);
        tick();
        start = 0;
        chk("start_state", {acc_busy, sat_flag, pulse_cnt}, {1'b1, 1'b0, 16'd0});
        for (int p = 0; p < tgt; p++) begin
            if (sat_t && p == 1) begin
                pre_en = 1;
                pre_addr = ADDR_W'(((b0 - 1 - BG_BINS) << IDX_W) + i0);
                pre_val = ACC_W'(MAX - 2);
                ref_sig[pre_addr] = pre_val;
                tick();
                pre_en = 0;
            end
            send_pulse(b0, nb, i0, ni, mode, cval, p == 0, inj && p == 0);
        end
        for (int k = 0; k < 50 && done_cnt == d0; k++) tick();
        chk("done_count", done_cnt - d0, 1);
        tick();
        chk("end_state", {acc_busy, SPEC_Acc_Done, pulse_cnt, sat_flag}, {2'b00, 16'(tgt), exp_sat});
        chk("write_count", wr_cnt - w0, n_exp - e0);
    endtask

    initial begin
        int ds, db;
        fork
            monitor();
        join_none
        #3 rst = 0;
        #4;
        chk("reset_a", {rdaddr_out, rd_bg_sel, wraddr_out, DPRAM_wea, DPRAM_BG_wea, acc_busy,
                        SPEC_Acc_Done, sat_flag}, 0);
        chk("reset_b", {wr_data_out, pulse_cnt}, 0);
        tick();
        tick();
        rst = 1;
        tick();
        run(1, 1, 4, 0, 4, 2, 0, 0, 0, 0, 0);
        chk("ramp_b3i2", sig_mem[2], 50);
        run(3, 3, 4, 0, 8, 0, 5, 0, 0, 0, 1);
        chk("acc15", sig_mem[5], 15);
        run(0, 3, 2, 10, 4, 1, 0, 0, 0, 0, 0);
        repeat (4) run($urandom_range(0, 3), $urandom_range(0, 28), $urandom_range(1, 3),
                       $urandom_range(0, 1000), $urandom_range(1, 8), 1, 0, 0, 0, 0, 0);
        run(2, 3, 1, 0, 2, 0, 7, 0, 0, 1, 0);
        chk("sat_word", sig_mem[0], MAX);
        run(2, 1, 4, 20, 4, 1, 0, 1, 0, 0, 0);
        run(1, 1, 4, 40, 4, 1, 0, 0, 1, 0, 0);
        BG_Deduction_En = 0;
        Peak_Detection_En = 0;
        exp_tgt = 16'd2;
        start = 1;
        pulse_num = 16'd2;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            data_valid_in = 1;
            RangeBin_Counter = 5;
            data_index = IDX_W'(i);
            data_in = DATA_W'(100 + i);
            model(5, i, data_in, 1);
            tick();
        end
        rst = 0;
        #1;
        chk("rst_mid_a", {rdaddr_out, rd_bg_sel, wraddr_out, DPRAM_wea, DPRAM_BG_wea, acc_busy,
                          SPEC_Acc_Done, sat_flag}, 0);
        chk("rst_mid_b", {wr_data_out, pulse_cnt}, 0);
        exp_q.delete();
        data_valid_in = 0;
        tick();
        tick();
        rst = 1;
        tick();
        run(1, 5, 1, 0, 3, 2, 0, 0, 0, 0, 0);
        ds = 0;
        db = 0;
        for (int a = 0; a < DEPTH; a++) begin
            ds += int'(sig_mem[a] !== ref_sig[a]);
            db += int'(bg_mem[a] !== ref_bg[a]);
        end
        chk("mem_sig", ds, 0);
        chk("mem_bg", db, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
